// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage that sits in front of pc_update. It holds the architectural fetch
// PC and reads the instruction memory over a read/waitrequest handshake. Each
// returned word is buffered with its PC+4 in a 2-entry queue, and the queue head
// is handed to decode/pc_update with valid/ready flow control. Redirects from
// pc_update take effect on the fetch after the one in flight, which gives the
// MIPS delay slot. Fetching to HALT_ADDR stops the stage.
//
// Ports:
//   clk               system clock, rising edge
//   reset             asynchronous, active-low reset
//   clk_enable        global advance enable; low freezes every register
//   pc_next[31:0]     redirect target from pc_update
//   pc_next_valid     pc_next applies to the next fetch
//   instr_address     instruction memory word address (current fetch PC)
//   instr_read        read request, held while instr_waitrequest is high
//   instr_waitrequest memory stall
//   instr_readdata    returned word, taken when instr_read && !instr_waitrequest
//   instruction       queue head word
//   pc4               queue head fetch address + 4
//   instr_valid       queue non-empty
//   instr_ready       consumer takes the head this cycle
//   active            high until the halt address is reached
//
// Optional build macro FETCH_PERF_CTR_EN adds fetch_count[31:0] and
// stall_count[31:0], both saturating performance counters.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000,
  parameter int          QDEPTH       = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] pc_next,
  input  logic        pc_next_valid,
  output logic [31:0] instr_address,
  output logic        instr_read,
  input  logic        instr_waitrequest,
  input  logic [31:0] instr_readdata,
  output logic [31:0] instruction,
  output logic [31:0] pc4,
  output logic        instr_valid,
  input  logic        instr_ready,
`ifdef FETCH_PERF_CTR_EN
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
`endif
  output logic        active
);

  // Queue is only built for two entries; QDEPTH sets the full threshold.
  localparam logic [1:0] QFULL = 2'(QDEPTH);

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] redir_q, redir_d;
  logic        pend_q, pend_d;
  logic        read_q, read_d;
  logic        active_q, active_d;
  logic        valid_q, valid_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] qw_q [2];
  logic [31:0] qw_d [2];
  logic [31:0] qp_q [2];
  logic [31:0] qp_d [2];

  logic        push_s;
  logic        pop_s;
  logic [31:0] seq_pc4_s;
  logic [31:0] next_fetch_s;

  // Next-state, queue and redirect bookkeeping; everything holds when clk_enable is low.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    redir_d   = redir_q;
    pend_d    = pend_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    qw_d      = qw_q;
    qp_d      = qp_q;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    seq_pc4_s = pc_q + 32'd4;

    // A redirect seen in the completing cycle is the latest one, so it wins
    // over any older pending redirect.
    if (pc_next_valid) begin
      next_fetch_s = {pc_next[31:2], 2'b00};
    end else if (pend_q) begin
      next_fetch_s = redir_q;
    end else begin
      next_fetch_s = seq_pc4_s;
    end

    if (clk_enable) begin
      if (pc_next_valid) begin
        redir_d = {pc_next[31:2], 2'b00};
        pend_d  = 1'b1;
      end else begin
        redir_d = redir_q;
        pend_d  = pend_q;
      end

      pop_s = instr_ready && (count_q != 2'd0);

      case (state_q)
        S_REQ: begin
          if (pc_q == HALT_ADDR) begin
            state_d = S_HALTED;
          end else if (count_q < QFULL) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_REQ;
          end
        end
        S_WAIT: begin
          if (!instr_waitrequest) begin
            push_s  = 1'b1;
            pc_d    = next_fetch_s;
            pend_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HALTED: begin
          state_d = S_HALTED;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase

      // Issue only happens with count < 2 and count cannot grow while the read
      // is outstanding, so a push never meets a full queue.
      if (push_s) begin
        qw_d[tail_q] = instr_readdata;
        qp_d[tail_q] = seq_pc4_s;
        tail_d       = ~tail_q;
      end else begin
        tail_d = tail_q;
      end

      if (pop_s) begin
        head_d = ~head_q;
      end else begin
        head_d = head_q;
      end

      case ({push_s, pop_s})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end else begin
      state_d = state_q;
    end

    // Outputs are registered from the next state so they change on the edge.
    read_d   = (state_d == S_WAIT);
    active_d = (state_d != S_HALTED);
    valid_d  = (count_d != 2'd0);
  end

  // State, PC, redirect and queue registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_VECTOR;
      redir_q  <= 32'd0;
      pend_q   <= 1'b0;
      read_q   <= 1'b0;
      active_q <= 1'b1;
      valid_q  <= 1'b0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        qw_q[i] <= 32'd0;
        qp_q[i] <= 32'd0;
      end
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      redir_q  <= redir_d;
      pend_q   <= pend_d;
      read_q   <= read_d;
      active_q <= active_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      for (int i = 0; i < 2; i++) begin
        qw_q[i] <= qw_d[i];
        qp_q[i] <= qp_d[i];
      end
    end
  end

  assign instr_address = pc_q;
  assign instr_read    = read_q;
  assign instruction   = qw_q[head_q];
  assign pc4           = qp_q[head_q];
  assign instr_valid   = valid_q;
  assign active        = active_q;

`ifdef FETCH_PERF_CTR_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_s;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    if (inc && (v != 32'hFFFFFFFF)) begin
      return v + 32'd1;
    end else begin
      return v;
    end
  endfunction

  // Counter updates: stalls are memory waits or a REQ blocked by a full queue.
  always_comb begin
    stall_s     = 1'b0;
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (clk_enable) begin
      stall_s = (read_q && instr_waitrequest) ||
                ((state_q == S_REQ) && (pc_q != HALT_ADDR) && (count_q >= QFULL));
      fetch_cnt_d = sat_inc(fetch_cnt_q, push_s);
      stall_cnt_d = sat_inc(stall_cnt_q, stall_s);
    end else begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. A transaction-level model (fetch PC,
// outstanding-read flag, pending redirect and a queue of {word, pc4}) is
// advanced on every rising edge; a compare process checks the DUT outputs
// against it on every falling edge. Directed sequences with hand-computed
// literal values pin the model, then a randomized phase exercises stalls,
// back-pressure, redirects and clock-enable gaps.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] HA = 32'h00000000;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [31:0] pc_next;
  logic        pc_next_valid;
  logic [31:0] instr_address;
  logic        instr_read;
  logic        instr_waitrequest;
  logic [31:0] instr_readdata;
  logic [31:0] instruction;
  logic [31:0] pc4;
  logic        instr_valid;
  logic        instr_ready;
  logic        active;
`ifdef FETCH_PERF_CTR_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_pc    = RV;
  logic [31:0] m_redir = 32'd0;
  bit          m_pend  = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_halt  = 1'b0;
  int          m_fetch = 0;
  logic [63:0] m_q[$];

  instr_fetch #(
    .RESET_VECTOR(RV),
    .HALT_ADDR   (HA),
    .QDEPTH      (2)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .clk_enable       (clk_enable),
    .pc_next          (pc_next),
    .pc_next_valid    (pc_next_valid),
    .instr_address    (instr_address),
    .instr_read       (instr_read),
    .instr_waitrequest(instr_waitrequest),
    .instr_readdata   (instr_readdata),
    .instruction      (instruction),
    .pc4              (pc4),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
`ifdef FETCH_PERF_CTR_EN
    .fetch_count      (fetch_count),
    .stall_count      (stall_count),
`endif
    .active           (active)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Memory returns a fresh random word every cycle.
  initial begin
    instr_readdata = 32'd0;
    forever begin
      @(negedge clk);
      instr_readdata = $urandom;
    end
  end

  // Reference model: advanced on each enabled rising edge, cleared by reset.
  initial begin
    int sz;
    bit do_pop;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_pc    = RV;
        m_redir = 32'd0;
        m_pend  = 1'b0;
        m_busy  = 1'b0;
        m_halt  = 1'b0;
        m_fetch = 0;
        m_q.delete();
      end else if (clk_enable) begin
        sz     = m_q.size();
        do_pop = (sz != 0) && instr_ready;
        if (pc_next_valid) begin
          m_redir = pc_next & 32'hFFFFFFFC;
          m_pend  = 1'b1;
        end
        if (m_busy) begin
          if (!instr_waitrequest) begin
            m_q.push_back({instr_readdata, m_pc + 32'd4});
            m_pc    = m_pend ? m_redir : (m_pc + 32'd4);
            m_pend  = 1'b0;
            m_busy  = 1'b0;
            m_fetch++;
          end
        end else if (!m_halt) begin
          if (m_pc == HA) begin
            m_halt = 1'b1;
          end else if (sz < 2) begin
            m_busy = 1'b1;
          end
        end
        if (do_pop) begin
          void'(m_q.pop_front());
        end
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  initial begin
    logic [63:0] hd;
    forever begin
      @(negedge clk);
      chk("valid", 32'(instr_valid), 32'(m_q.size() != 0));
      chk("active", 32'(active), 32'(!m_halt));
      chk("read", 32'(instr_read), 32'(m_busy));
      if (m_busy) begin
        chk("address", instr_address, m_pc);
      end
      if (m_q.size() != 0) begin
        hd = m_q[0];
        chk("instruction", instruction, hd[63:32]);
        chk("pc4", pc4, hd[31:0]);
      end
    end
  end

  task automatic wait_read();
    int n = 0;
    while (!instr_read && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!instr_read) begin
      failures++;
      $display("FAIL wait_read: instr_read=%b after %0d cycles, required 1", instr_read, n);
    end
  endtask

  initial begin
    logic [31:0] s_addr, s_instr, s_pc4;
    logic        s_read, s_valid, s_active;

    reset             = 1'b0;
    clk_enable        = 1'b1;
    pc_next           = 32'd0;
    pc_next_valid     = 1'b0;
    instr_waitrequest = 1'b0;
    instr_ready       = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_read", 32'(instr_read), 32'd0);
    chk("rst_instruction", instruction, 32'd0);
    chk("rst_pc4", pc4, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_active", 32'(active), 32'd1);
    #2 reset = 1'b1;

    // Zero-wait fetches, one every two cycles
    @(negedge clk);
    chk("f0_read", 32'(instr_read), 32'd1);
    chk("f0_addr", instr_address, 32'hBFC00000);
    @(negedge clk);
    chk("f0_valid", 32'(instr_valid), 32'd1);
    chk("f0_pc4", pc4, 32'hBFC00004);
    @(negedge clk);
    chk("f1_addr", instr_address, 32'hBFC00004);

    // Three wait cycles on BFC00004: address held four cycles, one push
    instr_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_addr", instr_address, 32'hBFC00004);
      chk("wait_read", 32'(instr_read), 32'd1);
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end
    instr_waitrequest = 1'b0;
    @(negedge clk);
    chk("wait_pc4", pc4, 32'hBFC00008);
    chk("wait_done_read", 32'(instr_read), 32'd0);
    @(negedge clk);
    chk("f2_addr", instr_address, 32'hBFC00008);
    chk("one_push_valid", 32'(instr_valid), 32'd0);

    // Misaligned redirect while BFC00008 is in flight
    instr_waitrequest = 1'b1;
    pc_next           = 32'hBFC00102;
    pc_next_valid     = 1'b1;
    @(negedge clk);
    pc_next_valid     = 1'b0;
    instr_waitrequest = 1'b0;
    @(negedge clk);
    chk("slot_pc4", pc4, 32'hBFC0000C);
    @(negedge clk);
    chk("redir_addr", instr_address, 32'hBFC00100);
    @(negedge clk);
    chk("redir_pc4", pc4, 32'hBFC00104);
    @(negedge clk);
    chk("redir_next_addr", instr_address, 32'hBFC00104);

    // Back-pressure fills the queue and stops requests
    instr_ready = 1'b0;
    repeat (6) @(negedge clk);
    chk("full_read", 32'(instr_read), 32'd0);
    chk("full_valid", 32'(instr_valid), 32'd1);
    chk("full_head_pc4", pc4, 32'hBFC00108);
    instr_ready = 1'b1;
    @(negedge clk);
    chk("drain_pc4", pc4, 32'hBFC0010C);
    @(negedge clk);
    chk("resume_addr", instr_address, 32'hBFC0010C);
    chk("resume_read", 32'(instr_read), 32'd1);

    // Clock enable low for five cycles: outputs frozen
    s_addr = instr_address; s_read = instr_read; s_instr = instruction;
    s_pc4 = pc4; s_valid = instr_valid; s_active = active;
    clk_enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      instr_ready   = 1'($urandom);
      pc_next_valid = 1'($urandom);
      pc_next       = {16'hBFC0, 16'($urandom)};
      @(negedge clk);
      chk("ce_addr", instr_address, s_addr);
      chk("ce_read", 32'(instr_read), 32'(s_read));
      chk("ce_instr", instruction, s_instr);
      chk("ce_pc4", pc4, s_pc4);
      chk("ce_valid", 32'(instr_valid), 32'(s_valid));
      chk("ce_active", 32'(active), 32'(s_active));
    end
    clk_enable    = 1'b1;
    instr_ready   = 1'b1;
    pc_next_valid = 1'b0;

    // Reset in the middle of a stalled read
    wait_read();
    instr_waitrequest = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_read", 32'(instr_read), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    instr_waitrequest = 1'b0;
    @(negedge clk);
    chk("midrst_first_addr", instr_address, RV);
    chk("midrst_first_read", 32'(instr_read), 32'd1);

    // Redirect to the halt address; queued word still drains
    instr_ready   = 1'b0;
    pc_next       = 32'h00000000;
    pc_next_valid = 1'b1;
    @(negedge clk);
    pc_next_valid = 1'b0;
    @(negedge clk);
    chk("halt_active", 32'(active), 32'd0);
    chk("halt_read", 32'(instr_read), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd1);
    repeat (4) @(negedge clk);
    chk("halt_stays", 32'(instr_read), 32'd0);
    instr_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("halt_drained", 32'(instr_valid), 32'd0);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rearm_active", 32'(active), 32'd1);
    @(negedge clk);
    chk("rearm_addr", instr_address, RV);

    // Randomized traffic, never redirecting to the halt address
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      clk_enable        = ($urandom_range(0, 9) != 0);
      instr_waitrequest = ($urandom_range(0, 2) == 0);
      instr_ready       = ($urandom_range(0, 4) < 3);
      pc_next_valid     = ($urandom_range(0, 15) == 0);
      pc_next           = {16'hBFC0, 16'($urandom)};
    end

    // Address wrap: FFFFFFFC + 4 = 0 halts
    @(negedge clk);
    clk_enable        = 1'b1;
    instr_waitrequest = 1'b0;
    instr_ready       = 1'b1;
    pc_next_valid     = 1'b0;
    wait_read();
    pc_next       = 32'hFFFFFFFC;
    pc_next_valid = 1'b1;
    @(negedge clk);
    pc_next_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("wrap_halt_active", 32'(active), 32'd0);
`ifdef FETCH_PERF_CTR_EN
    chk("fetch_count", fetch_count, 32'(m_fetch));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Fetch stage directly upstream of pc_update.
- Holds the architectural fetch PC and issues reads to the instruction memory over a read/waitrequest handshake.
- Buffers fetched words with their PC+4 in a 2-entry queue and presents {instruction, pc4} to decode and pc_update with valid/ready flow control.
- Accepts redirect addresses from pc_update and detects the halt address.

Parameters:
RESET_VECTOR, 32'hBFC00000, first fetch address after reset
HALT_ADDR, 32'h00000000, fetch target that ends execution
QDEPTH, 2, output queue entries (only 2 supported)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
clk_enable  in  1  global advance enable; low freezes all state
pc_next  in  32  redirect target from pc_update (pc_out_d)
pc_next_valid  in  1  pc_next applies to the next fetch
instr_address  out  32  instruction memory word address
instr_read  out  1  read request
instr_waitrequest  in  1  memory stall; read/address held while high
instr_readdata  in  32  returned word, valid when instr_read && !instr_waitrequest
instruction  out  32  queue head word
pc4  out  32  queue head fetch address + 4
instr_valid  out  1  queue non-empty
instr_ready  in  1  consumer accepts head this cycle
active  out  1  high until halt reached

Behaviour:
- Decided: one clock, clk. Reset port is reset, asynchronous and active-low.
- Reset (reset=0, any time, including mid-read):
  - pc=RESET_VECTOR; queue empty; state=REQ.
  - instr_read=0, instruction=0, pc4=0, instr_valid=0, active=1.
- A read in flight at reset is abandoned. Its data is never pushed.
- States:
  - REQ:
    - If pc==HALT_ADDR: go to HALTED, with no read issued.
    - Else if count<2: instr_read=1, instr_address=pc; go to WAIT.
    - Else: stay in REQ with instr_read=0.
  - WAIT:
    - instr_read=1, instr_address=pc held stable.
    - While waitrequest=1: stay.
    - When waitrequest=0: push {readdata, pc+4}; pc<=next; go to REQ.
  - HALTED: instr_read=0, active=0. Queue still drains. Left only by reset.
- Next-PC selection at completion:
  - pc_next if pc_next_valid was sampled high in any cycle since the previous completion; the latest such value wins.
  - Otherwise pc+4.
  - A 1-bit pending flag plus a 32-bit register holds the redirect until it is used.
- MIPS delay slot: the word already in flight or queued is never flushed. The redirect affects the following fetch only.
- Request timing:
  - A read is issued the cycle after entering REQ, i.e. a registered request.
  - Minimum 2 cycles per fetch with zero-wait memory.
- Queue:
  - 2 entries, head/tail pointers with wrap, count 0..2.
  - Pop when instr_valid && instr_ready.
  - Push and pop in the same cycle: count unchanged, no data lost.
  - Space is guaranteed at completion: issue requires count<2, and count only decreases while a read is outstanding.
  - Pop on empty is ignored.
- Address arithmetic: 32-bit modulo. pc+4 from 32'hFFFFFFFC wraps to 0, which then halts if HALT_ADDR=0.
- clk_enable=0:
  - No register changes: pc, state, queue, pending redirect all frozen.
  - Outputs hold their values. instr_read stays asserted if in WAIT.
  - A completion in this cycle is not captured; the memory must keep the same data until the next enabled cycle.
  - Pops are not performed.
- Misaligned pc_next (low bits ≠ 00): bits [1:0] forced to 0 before use.

Optional Feature:
FETCH_PERF_CTR_EN
- Defined:
  - Adds outputs fetch_count[31:0] and stall_count[31:0], both reset to 0.
  - fetch_count increments per completed read.
  - stall_count increments per enabled cycle with instr_read && instr_waitrequest, or with REQ blocked by a full queue.
  - Both saturate at 32'hFFFFFFFF and freeze while clk_enable=0.
- Undefined: ports and logic absent. Behaviour is otherwise identical.

Test Plan:
- Release reset, waitrequest=0, instr_ready=1:
  - cycle 1: instr_read=1, address=BFC00000.
  - Then BFC00004, BFC00008 every 2 cycles.
  - pc4 outputs BFC00004, BFC00008.
- waitrequest high 3 cycles on BFC00004: address and read stay stable 4 cycles; exactly one push; next address BFC00008.
- instr_ready=0 from start: queue fills after 2 fetches; instr_read drops and stays 0. Raising instr_ready pops BFC00000 first and fetching resumes at BFC00008.
- pc_next=BFC00100 pulsed while fetching BFC00004: next fetch is BFC00100 (delay-slot word not flushed), then BFC00104.
- pc_next=00000000: after the in-flight fetch completes, active=0, no further reads, queued words still drain. Reset low then high: active=1, fetch BFC00000.
- reset asserted mid-WAIT with waitrequest=1: instr_read=0 immediately, queue empty; after release the first address is BFC00000. clk_enable=0 for 5 cycles: all outputs constant.
